// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Fetch stage of a simple in-order pipeline. Issues word-aligned requests to
//   an instruction memory and presents returned words to the IF/ID register.
//   It can buffer one word while decode stalls, and it handles taken
//   branches/jumps resolved in ID. If a redirect arrives while a request is
//   still outstanding, the unit drains that stale response before it fetches
//   from the new target.
//
// Ports:
//   Clk            in   1   clock, all state updates on rising edge
//   Rst            in   1   asynchronous active-high reset
//   Stall          in   1   decode hazard hold (IF/ID must not advance)
//   Redirect       in   1   taken branch/jump resolved in ID this cycle
//   RedirectTarget in  32   new fetch address when Redirect=1
//   IMemAck        in   1   memory response valid (1-cycle pulse per request)
//   IMemData       in  32   instruction word, valid when IMemAck=1
//   IMemReq        out  1   fetch request
//   IMemAddr       out 32   fetch address (word aligned)
//   PCAddress      out 32   PC+4 of the presented instruction
//   Instruction    out 32   instruction word to IF/ID
//   IF_ID_en       out  1   IF/ID write enable
//   IF_Flush       out  1   IF/ID bubble insert
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] PCAddress,
  output logic [31:0] Instruction,
  output logic        IF_ID_en,
  output logic        IF_Flush
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // PC and ReqAddr only ever take aligned values (aligned reset value, +4,
  // aligned redirect target), so IMemAddr[1:0] is always 2'b00.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_buf_q, instr_buf_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        unused_target_bits;

  assign pc_plus4           = pc_q + 32'd4;  // wraps modulo 2^32
  assign redirect_pc        = {RedirectTarget[31:2], 2'b00};
  assign unused_target_bits = ^RedirectTarget[1:0];

  // The outputs are decoded combinationally from the registered state and the
  // current inputs. This lets a word that is acknowledged in a cycle reach
  // IF/ID in that same cycle, with no added fetch latency.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    instr_buf_d = instr_buf_q;
    IMemReq     = 1'b0;
    IMemAddr    = 32'h0;
    PCAddress   = 32'h0;
    Instruction = 32'h0;
    IF_ID_en    = 1'b0;
    IF_Flush    = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        IMemReq  = 1'b1;
        IMemAddr = pc_q;
        if (Redirect) begin
          IF_ID_en = 1'b1;
          IF_Flush = 1'b1;
          pc_d     = redirect_pc;
          if (!IMemAck) begin
            // The old request is still in flight. Remember it so that its
            // response can be swallowed before fetching from the new target.
            req_addr_d = pc_q;
            state_d    = S_DRAIN;
          end
        end else if (IMemAck) begin
          if (!Stall) begin
            IF_ID_en    = 1'b1;
            Instruction = IMemData;
            PCAddress   = pc_plus4;
            pc_d        = pc_plus4;
          end else begin
            instr_buf_d = IMemData;
            state_d     = S_HOLD;
          end
        end else if (!Stall) begin
          IF_ID_en = 1'b1;
          IF_Flush = 1'b1;
        end
      end

      S_HOLD: begin
        if (Redirect) begin
          IF_ID_en = 1'b1;
          IF_Flush = 1'b1;
          pc_d     = redirect_pc;
          state_d  = S_FETCH;
        end else if (!Stall) begin
          IF_ID_en    = 1'b1;
          Instruction = instr_buf_q;
          PCAddress   = pc_plus4;
          pc_d        = pc_plus4;
          state_d     = S_FETCH;
        end
      end

      S_DRAIN: begin
        IMemReq  = 1'b1;
        IMemAddr = req_addr_q;
        IF_ID_en = 1'b1;
        IF_Flush = 1'b1;
        if (Redirect) begin
          pc_d = redirect_pc;
        end
        if (IMemAck) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC_ALIGNED;
      req_addr_q  <= 32'h0;
      instr_buf_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      instr_buf_q <= instr_buf_d;
    end
  end

endmodule
